// File: rtl/adjust_state_pkg.sv
// -----------------------------------------------------------------------------
// adjust_state_pkg
// Shared definitions for the clock/alarm adjust state machine.
//   state_e          : 3-bit state encoding (code 3'd7 unused, recovers to NORM)
//   DEF_TOUT_TICKS   : default inactivity timeout in SIG2HZ rising edges (30 s)
//   DEF_RPT_DLY      : default SIG2HZ rising edges before auto-repeat starts
//   DEF_TW           : default counter width
//   is_alarm()       : true for the states that display the alarm registers
// -----------------------------------------------------------------------------
package adjust_state_pkg;

    typedef enum logic [2:0] {
        ST_NORM  = 3'd0,
        ST_SEC   = 3'd1,
        ST_MIN   = 3'd2,
        ST_HOUR  = 3'd3,
        ST_ANORM = 3'd4,
        ST_AMIN  = 3'd5,
        ST_AHOUR = 3'd6
    } state_e;

    localparam int DEF_TOUT_TICKS = 60;
    localparam int DEF_RPT_DLY    = 2;
    localparam int DEF_TW         = 8;

    function automatic logic is_alarm(input state_e s);
        return (s == ST_ANORM) || (s == ST_AMIN) || (s == ST_AHOUR);
    endfunction

endpackage

// File: rtl/adjust_state_if.sv
// -----------------------------------------------------------------------------
// adjust_state_if
// Key / display bundle between the key scanner + display driver (master) and
// the adjust state machine (slave).
//   SIG2HZ, HOUR10, MODE, SELECT, ADJUST, ADJHOLD      : master -> slave
//   SECCLR, MININC, HOURINC, AMININC, AHOURINC         : slave -> master pulses
//   SECON, MINON, HOURON1, HOURON10, ALMSEL            : slave -> master levels
// -----------------------------------------------------------------------------
interface adjust_state_if;
    logic       SIG2HZ;
    logic [1:0] HOUR10;
    logic       MODE;
    logic       SELECT;
    logic       ADJUST;
    logic       ADJHOLD;
    logic       SECCLR;
    logic       MININC;
    logic       HOURINC;
    logic       AMININC;
    logic       AHOURINC;
    logic       SECON;
    logic       MINON;
    logic       HOURON1;
    logic       HOURON10;
    logic       ALMSEL;

    modport slave (
        input  SIG2HZ, HOUR10, MODE, SELECT, ADJUST, ADJHOLD,
        output SECCLR, MININC, HOURINC, AMININC, AHOURINC,
        output SECON, MINON, HOURON1, HOURON10, ALMSEL
    );

    modport master (
        output SIG2HZ, HOUR10, MODE, SELECT, ADJUST, ADJHOLD,
        input  SECCLR, MININC, HOURINC, AMININC, AHOURINC,
        input  SECON, MINON, HOURON1, HOURON10, ALMSEL
    );
endinterface

// File: rtl/adjust_state_auto_repeat.sv
// -----------------------------------------------------------------------------
// auto_repeat
// Counts SIG2HZ ticks while the ADJUST key is held; once RPT_DLY ticks have
// elapsed every further tick becomes a repeat pulse.
//   CLK, RST (async active-low), tick (1-cycle SIG2HZ rise), ADJHOLD (level),
//   clr (state change) -> rpt (repeat pulse), repeating (level, hold active)
// -----------------------------------------------------------------------------
module auto_repeat
    import adjust_state_pkg::*;
#(
    parameter int RPT_DLY = DEF_RPT_DLY,
    parameter int TW      = DEF_TW
) (
    input  logic CLK,
    input  logic RST,
    input  logic tick,
    input  logic ADJHOLD,
    input  logic clr,
    output logic rpt,
    output logic repeating
);

    localparam logic [TW-1:0] RPT_C = TW'(RPT_DLY);

    logic [TW-1:0] r_cnt;
    logic          w_full;

    assign w_full = (r_cnt == RPT_C);

    // Hold-time counter, saturating so the repeat rate stays one per tick.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt <= {TW{1'b0}};
        end else if (!ADJHOLD || clr) begin
            r_cnt <= {TW{1'b0}};
        end else if (tick && !w_full) begin
            r_cnt <= r_cnt + TW'(1'b1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Repeat status decode.
    always_comb begin
        repeating = ADJHOLD & w_full;
        rpt       = tick & repeating;
    end

endmodule

// File: rtl/adjust_state.sv
// -----------------------------------------------------------------------------
// adjust_state
// Mode/select state machine for setting the time and alarm of a digital clock.
// Generates single-cycle increment/clear pulses (with auto-repeat while ADJUST
// is held), blinks the digit being adjusted, and falls back to NORM after
// TOUT_TICKS SIG2HZ rising edges without key activity.
//   CLK  : system clock, rising edge
//   RST  : asynchronous active-low reset
//   bus  : adjust_state_if.slave (keys, SIG2HZ, HOUR10 in; pulses, enables out)
// -----------------------------------------------------------------------------
module adjust_state
    import adjust_state_pkg::*;
#(
    parameter int TOUT_TICKS = DEF_TOUT_TICKS,
    parameter int RPT_DLY    = DEF_RPT_DLY,
    parameter int TW         = DEF_TW
) (
    input  logic           CLK,
    input  logic           RST,
    adjust_state_if.slave  bus
);

    localparam logic [TW-1:0] TOUT_C = TW'(TOUT_TICKS);

    state_e        r_state;
    state_e        w_key_next;
    state_e        w_next;
    logic          r_sig_prev;
    logic [TW-1:0] r_inact;
    logic          w_tick;
    logic          w_key;
    logic          w_chg;
    logic          w_tout;
    logic          w_rpt;
    logic          w_repeating;
    logic          w_blink;

    assign w_tick = bus.SIG2HZ & ~r_sig_prev;
    assign w_key  = bus.MODE | bus.SELECT | bus.ADJUST;
    // Any key pulse in the timeout cycle counts as activity and wins.
    assign w_tout = (r_inact == TOUT_C) & ~w_key;
    assign w_next = w_tout ? ST_NORM : w_key_next;
    assign w_chg  = (w_next != r_state);

    // SIG2HZ previous sample for rising-edge detection.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sig_prev <= 1'b0;
        end else begin
            r_sig_prev <= bus.SIG2HZ;
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_NORM;
        end else begin
            r_state <= w_next;
        end
    end

    // Inactivity counter; NORM never times out so it does not count there.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_inact <= {TW{1'b0}};
        end else if (w_key || bus.ADJHOLD || w_chg) begin
            r_inact <= {TW{1'b0}};
        end else if (w_tick && (r_state != ST_NORM)) begin
            r_inact <= r_inact + TW'(1'b1);
        end else begin
            r_inact <= r_inact;
        end
    end

    // Key-driven next state, MODE before SELECT.
    always_comb begin
        w_key_next = ST_NORM;
        case (r_state)
            ST_NORM:  w_key_next = bus.MODE ? ST_SEC   : (bus.SELECT ? ST_ANORM : ST_NORM);
            ST_SEC:   w_key_next = bus.MODE ? ST_NORM  : (bus.SELECT ? ST_MIN   : ST_SEC);
            ST_MIN:   w_key_next = bus.MODE ? ST_NORM  : (bus.SELECT ? ST_HOUR  : ST_MIN);
            ST_HOUR:  w_key_next = bus.MODE ? ST_NORM  : (bus.SELECT ? ST_SEC   : ST_HOUR);
            ST_ANORM: w_key_next = bus.MODE ? ST_AMIN  : (bus.SELECT ? ST_NORM  : ST_ANORM);
            ST_AMIN:  w_key_next = bus.MODE ? ST_ANORM : (bus.SELECT ? ST_AHOUR : ST_AMIN);
            ST_AHOUR: w_key_next = bus.MODE ? ST_ANORM : (bus.SELECT ? ST_AMIN  : ST_AHOUR);
            default:  w_key_next = ST_NORM;
        endcase
    end

    auto_repeat #(
        .RPT_DLY (RPT_DLY),
        .TW      (TW)
    ) u_rpt (
        .CLK       (CLK),
        .RST       (RST),
        .tick      (w_tick),
        .ADJHOLD   (bus.ADJHOLD),
        .clr       (w_chg),
        .rpt       (w_rpt),
        .repeating (w_repeating)
    );

    // Output decode from the current state, so a key coincident with a
    // transition still acts on the state being left.
    always_comb begin
        w_blink      = bus.SIG2HZ & ~w_repeating;
        bus.SECCLR   = (r_state == ST_SEC)   & bus.ADJUST;
        bus.MININC   = (r_state == ST_MIN)   & (bus.ADJUST | w_rpt);
        bus.HOURINC  = (r_state == ST_HOUR)  & (bus.ADJUST | w_rpt);
        bus.AMININC  = (r_state == ST_AMIN)  & (bus.ADJUST | w_rpt);
        bus.AHOURINC = (r_state == ST_AHOUR) & (bus.ADJUST | w_rpt);
        bus.SECON    = ~((r_state == ST_SEC) & w_blink);
        bus.MINON    = ~(((r_state == ST_MIN) | (r_state == ST_AMIN)) & w_blink);
        bus.HOURON1  = ~(((r_state == ST_HOUR) | (r_state == ST_AHOUR)) & w_blink);
        // Leading-zero blanking of the tens-of-hours digit in display states.
        bus.HOURON10 = ~((((r_state == ST_HOUR) | (r_state == ST_AHOUR)) & w_blink) |
                         (((r_state == ST_NORM) | (r_state == ST_ANORM)) & (bus.HOUR10 == 2'd0)));
        bus.ALMSEL   = is_alarm(r_state);
    end

endmodule

// File: tb/tb_adjust_state.sv
module tb_adjust_state;

    logic CLK = 1'b0;
    logic RST;
    int   total = 0;
    int   bad   = 0;

    always #5 CLK = ~CLK;

    adjust_state_if bus ();

    adjust_state #(
        .TOUT_TICKS (4),
        .RPT_DLY    (2),
        .TW         (8)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    // {SECCLR,MININC,HOURINC,AMININC,AHOURINC,SECON,MINON,HOURON1,HOURON10,ALMSEL}
    typedef struct packed {
        logic       m;
        logic       s;
        logic       a;
        logic       sig;
        logic [1:0] h10;
        logic [2:0] st;
        logic [9:0] o;
    } vec_t;

    vec_t tv [21];

    function automatic logic [9:0] outs();
        return {bus.SECCLR, bus.MININC, bus.HOURINC, bus.AMININC, bus.AHOURINC,
                bus.SECON, bus.MINON, bus.HOURON1, bus.HOURON10, bus.ALMSEL};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One clock cycle: inputs applied 1 ns after the edge, outputs settle by +3 ns.
    task automatic cyc(input logic m, input logic s, input logic a, input logic h, input logic sig);
        @(posedge CLK);
        #1;
        bus.MODE    = m;
        bus.SELECT  = s;
        bus.ADJUST  = a;
        bus.ADJHOLD = h;
        bus.SIG2HZ  = sig;
        #2;
    endtask

    initial begin
        // States: NORM0 SEC1 MIN2 HOUR3 ANORM4 AMIN5 AHOUR6
        tv[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 10'b0000011100};
        tv[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0, 10'b0000011110};
        tv[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0, 10'b0000011110};
        tv[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 3'd1, 10'b0000001110};
        tv[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 3'd2, 10'b0000011110};
        tv[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 3'd3, 10'b0010011110};
        tv[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 3'd1, 10'b1000011110};
        tv[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 3'd1, 10'b0000011110};
        tv[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 3'd2, 10'b0100010110};
        tv[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 3'd2, 10'b0100011110};
        tv[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 10'b0000011100};
        tv[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd4, 10'b0000011101};
        tv[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 3'd4, 10'b0000011111};
        tv[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 3'd4, 10'b0000011111};
        tv[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 3'd5, 10'b0001011111};
        tv[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 3'd5, 10'b0001011111};
        tv[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 3'd6, 10'b0000111001};
        tv[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 3'd6, 10'b0000011111};
        tv[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 3'd5, 10'b0000011111};
        tv[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 3'd4, 10'b0000011111};
        tv[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 3'd0, 10'b0000011110};

        RST         = 1'b0;
        bus.MODE    = 1'b0;
        bus.SELECT  = 1'b0;
        bus.ADJUST  = 1'b0;
        bus.ADJHOLD = 1'b0;
        bus.SIG2HZ  = 1'b0;
        bus.HOUR10  = 2'd0;

        // Reset state
        @(posedge CLK); #3;
        chk("rst_outs_h0", 32'(outs()), 32'b0000011100);
        chk("rst_state", 32'(dut.r_state), 32'd0);
        bus.HOUR10 = 2'd1;
        #1;
        chk("rst_outs_h1", 32'(outs()), 32'b0000011110);
        @(posedge CLK); #1;
        RST = 1'b1;

        // Table: transitions, pulses, blink, blanking, ALMSEL
        for (int i = 0; i < 21; i++) begin
            @(posedge CLK);
            #1;
            bus.MODE    = tv[i].m;
            bus.SELECT  = tv[i].s;
            bus.ADJUST  = tv[i].a;
            bus.ADJHOLD = 1'b0;
            bus.SIG2HZ  = tv[i].sig;
            bus.HOUR10  = tv[i].h10;
            #2;
            chk($sformatf("vec%0d_state", i), 32'(dut.r_state), 32'(tv[i].st));
            chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(tv[i].o));
        end

        // Auto-repeat in MIN
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("rpt_state_min", 32'(dut.r_state), 32'd2);
        chk("rpt_adjust_mininc", 32'(bus.MININC), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            chk($sformatf("rpt_tick%0d_mininc", k), 32'(bus.MININC), 32'(k >= 3));
            chk($sformatf("rpt_tick%0d_minon", k), 32'(bus.MINON), 32'(k >= 3));
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            chk($sformatf("rpt_low%0d_mininc", k), 32'(bus.MININC), 32'd0);
            chk($sformatf("rpt_low%0d_minon", k), 32'(bus.MINON), 32'd1);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rpt_release_mininc", 32'(bus.MININC), 32'd0);

        // Timeout in AHOUR
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("tout_k%0d_state", k), 32'(dut.r_state), 32'd6);
        end
        chk("tout_count", 32'(dut.r_inact), 32'd4);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("tout_to_norm", 32'(dut.r_state), 32'd0);

        // Timeout cycle with SELECT: the key wins
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            if (k < 4) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("tout_sel_state_ahour", 32'(dut.r_state), 32'd6);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("tout_sel_to_amin", 32'(dut.r_state), 32'd5);

        // Reset during HOUR repeat
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("hr_state", 32'(dut.r_state), 32'd3);
        chk("hr_adjust_hourinc", 32'(bus.HOURINC), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            chk($sformatf("hr_tick%0d_hourinc", k), 32'(bus.HOURINC), 32'(k == 3));
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        @(posedge CLK);
        #1;
        bus.SIG2HZ = 1'b1;
        bus.HOUR10 = 2'd0;
        RST        = 1'b0;
        #2;
        chk("rst_mid_outs", 32'(outs()), 32'b0000011100);
        @(posedge CLK);
        #3;
        chk("rst_mid_state", 32'(dut.r_state), 32'd0);
        chk("rst_mid_inact", 32'(dut.r_inact), 32'd0);
        chk("rst_mid_rptcnt", 32'(dut.u_rpt.r_cnt), 32'd0);
        chk("rst_mid_hourinc", 32'(bus.HOURINC), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'(k % 2));
            chk($sformatf("post_rst%0d_pulses", k), 32'(outs() >> 5), 32'd0);
            chk($sformatf("post_rst%0d_state", k), 32'(dut.r_state), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
